// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, legality check and the arbiter FSM states.
// Imported by the ALU, the arbiter and every other ALU client.
package alu_pkg;

  localparam logic [2:0] ALU_SUB  = 3'b000;
  localparam logic [2:0] ALU_NEG  = 3'b001;
  localparam logic [2:0] ALU_INC  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_state_e;

  function automatic logic alu_op_legal(input logic [2:0] op);
    case (op)
      ALU_SUB, ALU_NEG, ALU_INC, ALU_ADD, ALU_PASS: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. The pointer names the requester that wins a tie and
// moves to the other requester whenever a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: round-robin grant,
// operand latch, one execute cycle, registered result with per-requester flags.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic [1:0]       in_req_valid,
  input  logic [WIDTH-1:0] in_req_a0,
  input  logic [WIDTH-1:0] in_req_a1,
  input  logic [WIDTH-1:0] in_req_b0,
  input  logic [WIDTH-1:0] in_req_b1,
  input  logic [2:0]       in_req_op0,
  input  logic [2:0]       in_req_op1,
  output logic [1:0]       out_req_ready,
  output logic [WIDTH-1:0] out_alu_a,
  output logic [WIDTH-1:0] out_alu_b,
  output logic [2:0]       out_alu_op,
  input  logic [WIDTH-1:0] in_alu_result,
  input  logic             in_alu_zero,
  input  logic             in_alu_neg,
  output logic             out_rsp_valid,
  output logic             out_rsp_id,
  output logic [WIDTH-1:0] out_rsp_result,
  output logic             out_rsp_zero,
  output logic             out_rsp_neg,
  output logic             out_rsp_err,
  input  logic             in_rsp_ready
);

  alu_state_e       state, state_nx;
  logic [1:0]       grant;
  logic             grant_id;
  logic             accept;
  logic             req_legal;

  logic [WIDTH-1:0] req_a, req_b;
  logic [2:0]       req_op;

  logic [WIDTH-1:0] lat_a, lat_b;
  logic [2:0]       lat_op;
  logic             lat_id;

  logic [1:0]       flag_zero, flag_neg;

  logic [WIDTH-1:0] rsp_result;
  logic             rsp_id, rsp_zero, rsp_neg, rsp_err;

  rr_arb2 u_arb (
    .clk    (in_clk),
    .rst_n  (in_rst_n),
    .valid  (in_req_valid),
    .advance(accept),
    .grant  (grant)
  );

  assign grant_id = grant[1];

  always_comb begin
    req_a  = grant_id ? in_req_a1  : in_req_a0;
    req_b  = grant_id ? in_req_b1  : in_req_b0;
    req_op = grant_id ? in_req_op1 : in_req_op0;
  end

  assign req_legal = alu_op_legal(req_op);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The ALU sees a PASS of zero outside EXEC so its own flags stay untouched.
  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    out_req_ready = '0;
    out_rsp_valid = 1'b0;
    out_alu_op    = ALU_PASS;
    out_alu_a     = '0;
    out_alu_b     = '0;
    case (state)
      IDLE: begin
        out_req_ready = grant;
        accept        = |(grant & in_req_valid);
        if (accept) begin
          state_nx = req_legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        out_alu_op = lat_op;
        out_alu_a  = lat_a;
        out_alu_b  = lat_b;
        state_nx   = RESP;
      end
      RESP: begin
        out_rsp_valid = 1'b1;
        if (in_rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      lat_a  <= '0;
      lat_b  <= '0;
      lat_op <= ALU_PASS;
      lat_id <= 1'b0;
    end else if (accept) begin
      lat_a  <= req_a;
      lat_b  <= req_b;
      lat_op <= req_op;
      lat_id <= grant_id;
    end
  end

  // Illegal ops skip EXEC and answer straight from accept with the requester's own flags.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rsp_result <= '0;
      rsp_id     <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_neg    <= 1'b0;
      rsp_err    <= 1'b0;
      flag_zero  <= '0;
      flag_neg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !req_legal) begin
            rsp_result <= '0;
            rsp_id     <= grant_id;
            rsp_err    <= 1'b1;
            rsp_zero   <= flag_zero[grant_id];
            rsp_neg    <= flag_neg[grant_id];
          end
        end
        EXEC: begin
          rsp_result <= in_alu_result;
          rsp_id     <= lat_id;
          rsp_err    <= 1'b0;
          if (lat_op == ALU_PASS) begin
            rsp_zero <= flag_zero[lat_id];
            rsp_neg  <= flag_neg[lat_id];
          end else begin
            rsp_zero          <= in_alu_zero;
            rsp_neg           <= in_alu_neg;
            flag_zero[lat_id] <= in_alu_zero;
            flag_neg[lat_id]  <= in_alu_neg;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_rsp_result = rsp_result;
  assign out_rsp_id     = rsp_id;
  assign out_rsp_zero   = rsp_zero;
  assign out_rsp_neg    = rsp_neg;
  assign out_rsp_err    = rsp_err;

  a_ready_onehot: assert property (@(posedge in_clk) disable iff (!in_rst_n)
    $onehot0(out_req_ready));

  a_alu_op_legal: assert property (@(posedge in_clk) disable iff (!in_rst_n)
    alu_op_legal(out_alu_op));

  a_no_accept_in_resp: assert property (@(posedge in_clk) disable iff (!in_rst_n)
    out_rsp_valid |-> out_req_ready == 2'b00);

  a_rsp_stable: assert property (@(posedge in_clk) disable iff (!in_rst_n)
    out_rsp_valid && !in_rsp_ready |=> out_rsp_valid &&
      $stable({out_rsp_id, out_rsp_result, out_rsp_zero, out_rsp_neg, out_rsp_err}));

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised scoreboard bench for alu_arbiter with a behavioural ALU and reference model.
module tb_alu_arbiter;

  localparam int W = 32;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  typedef struct {
    logic         id;
    logic [W-1:0] result;
    logic         zero;
    logic         neg;
    logic         err;
    int           acc_cyc;
  } exp_t;

  logic         clk;
  logic         in_rst_n;
  logic [1:0]   in_req_valid;
  logic [W-1:0] in_req_a0, in_req_a1, in_req_b0, in_req_b1;
  logic [2:0]   in_req_op0, in_req_op1;
  logic [1:0]   out_req_ready;
  logic [W-1:0] out_alu_a, out_alu_b;
  logic [2:0]   out_alu_op;
  logic [W-1:0] in_alu_result;
  logic         in_alu_zero, in_alu_neg;
  logic         out_rsp_valid, out_rsp_id;
  logic [W-1:0] out_rsp_result;
  logic         out_rsp_zero, out_rsp_neg, out_rsp_err;
  logic         in_rsp_ready;

  alu_arbiter #(.WIDTH(W)) dut (
    .in_clk        (clk),
    .in_rst_n      (in_rst_n),
    .in_req_valid  (in_req_valid),
    .in_req_a0     (in_req_a0),
    .in_req_a1     (in_req_a1),
    .in_req_b0     (in_req_b0),
    .in_req_b1     (in_req_b1),
    .in_req_op0    (in_req_op0),
    .in_req_op1    (in_req_op1),
    .out_req_ready (out_req_ready),
    .out_alu_a     (out_alu_a),
    .out_alu_b     (out_alu_b),
    .out_alu_op    (out_alu_op),
    .in_alu_result (in_alu_result),
    .in_alu_zero   (in_alu_zero),
    .in_alu_neg    (in_alu_neg),
    .out_rsp_valid (out_rsp_valid),
    .out_rsp_id    (out_rsp_id),
    .out_rsp_result(out_rsp_result),
    .out_rsp_zero  (out_rsp_zero),
    .out_rsp_neg   (out_rsp_neg),
    .out_rsp_err   (out_rsp_err),
    .in_rsp_ready  (in_rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      3'b100:  return b + a;
      3'b010:  return a + W'(1);
      3'b001:  return W'(0) - a;
      3'b000:  return b - a;
      3'b111:  return a;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic op_ok(input logic [2:0] op);
    return op inside {3'b100, 3'b010, 3'b001, 3'b000, 3'b111};
  endfunction

  // Behavioural ALU; on PASS its flags are random so the arbiter must ignore them.
  logic [1:0] junk = 2'b00;
  always @(posedge clk) junk <= 2'($urandom);
  always_comb begin
    in_alu_result = ref_alu(out_alu_op, out_alu_a, out_alu_b);
    in_alu_zero   = (out_alu_op == 3'b111) ? junk[0] : (in_alu_result == '0);
    in_alu_neg    = (out_alu_op == 3'b111) ? junk[1] : in_alu_result[W-1];
  end

  exp_t sbq[$];
  req_t pend0[$], pend1[$];
  req_t cur[2];
  int   m_ptr;
  logic mz[2], mn[2];
  bit   rnd_gaps, rdy_force, rdy_val;
  int   timeouts = 0;

  int   checks = 0;
  int   failures = 0;

  // ---------------- monitor / checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    exp_t e;
    bit   have_cur;
    int   timeouts_seen;
    have_cur      = 0;
    timeouts_seen = 0;
    forever begin
      @(negedge clk);
      if (timeouts != timeouts_seen) begin
        chk("wait_bound", 64'(timeouts), 64'(timeouts_seen));
        timeouts_seen = timeouts;
      end
      if (!in_rst_n) begin
        chk("rst_rsp", {out_rsp_valid, out_rsp_id, out_rsp_result, out_rsp_zero, out_rsp_neg,
                        out_rsp_err}, '0);
        chk("rst_alu", {out_alu_op, out_alu_a, out_alu_b}, {3'b111, 64'd0});
        if (in_req_valid == 2'b00) chk("rst_ready", out_req_ready, 0);
        sbq.delete();
        have_cur = 0;
        continue;
      end
      chk("ready_onehot0", (out_req_ready & (out_req_ready - 2'd1)) == 2'b00, 1);
      chk("alu_op_legal", op_ok(out_alu_op), 1);
      if (out_rsp_valid) begin
        chk("ready_in_resp", out_req_ready, 0);
        if (!have_cur) begin
          if (sbq.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
            e = '{id: 0, result: '0, zero: 0, neg: 0, err: 0, acc_cyc: 0};
          end else begin
            e = sbq.pop_front();
            chk("latency", 64'(cyc - e.acc_cyc), e.err ? 64'd1 : 64'd2);
          end
          have_cur = 1;
        end
        chk("rsp_id", out_rsp_id, e.id);
        chk("rsp_result", out_rsp_result, e.result);
        chk("rsp_flags", {out_rsp_zero, out_rsp_neg}, {e.zero, e.neg});
        chk("rsp_err", out_rsp_err, e.err);
        if (in_rsp_ready) have_cur = 0;
      end
    end
  end

  // ---------------- stimulus / reference model ----------------
  task automatic push_expect(input int w);
    exp_t e;
    e.id      = w[0];
    e.acc_cyc = cyc;
    e.err     = !op_ok(cur[w].op);
    if (e.err) begin
      e.result = '0;
      e.zero   = mz[w];
      e.neg    = mn[w];
    end else begin
      e.result = ref_alu(cur[w].op, cur[w].a, cur[w].b);
      if (cur[w].op == 3'b111) begin
        e.zero = mz[w];
        e.neg  = mn[w];
      end else begin
        e.zero = (e.result == '0);
        e.neg  = e.result[W-1];
        mz[w]  = e.zero;
        mn[w]  = e.neg;
      end
    end
    sbq.push_back(e);
  endtask

  task automatic step();
    logic [1:0] acc;
    int w;
    @(negedge clk);
    acc = out_req_ready & in_req_valid;
    if (in_rst_n && acc != 2'b00) begin
      w = (in_req_valid == 2'b11) ? m_ptr : (in_req_valid[1] ? 1 : 0);
      push_expect(w);
      m_ptr = 1 - w;
    end
    @(posedge clk);
    #2;
    if (acc[0]) in_req_valid[0] = 1'b0;
    if (acc[1]) in_req_valid[1] = 1'b0;
    if (!in_req_valid[0] && pend0.size() > 0 && (!rnd_gaps || $urandom_range(0, 2) == 0)) begin
      cur[0] = pend0.pop_front();
      in_req_op0 = cur[0].op; in_req_a0 = cur[0].a; in_req_b0 = cur[0].b;
      in_req_valid[0] = 1'b1;
    end
    if (!in_req_valid[1] && pend1.size() > 0 && (!rnd_gaps || $urandom_range(0, 2) == 0)) begin
      cur[1] = pend1.pop_front();
      in_req_op1 = cur[1].op; in_req_a1 = cur[1].a; in_req_b1 = cur[1].b;
      in_req_valid[1] = 1'b1;
    end
    in_rsp_ready = rdy_force ? rdy_val : ($urandom_range(0, 2) != 0);
  endtask

  task automatic req(input int id, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b);
    req_t r;
    r.op = op; r.a = a; r.b = b;
    if (id == 0) pend0.push_back(r);
    else         pend1.push_back(r);
  endtask

  task automatic drain(input int bound);
    bit done;
    done = 0;
    for (int k = 0; k < bound; k++) begin
      done = pend0.size() == 0 && pend1.size() == 0 && in_req_valid == 2'b00 &&
             sbq.size() == 0 && !out_rsp_valid;
      if (done) break;
      step();
    end
    if (!done) timeouts++;
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 3));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    bit seen;
    in_rst_n = 1'b0;
    in_req_valid = '0;
    in_req_a0 = '0; in_req_a1 = '0; in_req_b0 = '0; in_req_b1 = '0;
    in_req_op0 = '0; in_req_op1 = '0;
    in_rsp_ready = 1'b1;
    rnd_gaps = 0; rdy_force = 1; rdy_val = 1;
    m_ptr = 0;
    mz[0] = 0; mz[1] = 0; mn[0] = 0; mn[1] = 0;
    repeat (3) step();
    in_rst_n = 1'b1;

    // contention straight after reset, then strict alternation
    req(0, 3'b010, 1, 0);
    req(1, 3'b000, 3, 3);
    for (int i = 0; i < 3; i++) begin
      req(0, 3'b100, W'($urandom), W'($urandom));
      req(1, 3'b001, W'($urandom_range(0, 2)), 0);
    end
    drain(100);

    req(0, 3'b100, 5, 7);
    drain(20);

    // flag isolation between requesters
    req(1, 3'b000, 1, 0);
    drain(20);
    req(0, 3'b111, 9, W'($urandom));
    drain(20);

    req(1, 3'b101, W'($urandom), W'($urandom));
    drain(20);

    // backpressure with a second request waiting
    rdy_val = 0;
    req(0, 3'b100, 32'h10, 32'h20);
    req(1, 3'b010, 32'hFFFF_FFFF, 0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = out_rsp_valid;
    end
    if (!seen) timeouts++;
    repeat (10) step();
    rdy_val = 1;
    drain(40);

    // random traffic with random gaps and response backpressure
    rnd_gaps = 1; rdy_force = 0;
    for (int i = 0; i < 40; i++) begin
      req(0, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
      req(1, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
    end
    drain(3000);

    // reset in the middle of EXEC
    rnd_gaps = 0; rdy_force = 1; rdy_val = 1;
    req(0, 3'b100, 1, 2);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = (out_alu_op == 3'b100);
    end
    if (!seen) timeouts++;
    #1;
    in_rst_n = 1'b0;
    in_req_valid = '0;
    pend0.delete(); pend1.delete();
    m_ptr = 0;
    mz[0] = 0; mz[1] = 0; mn[0] = 0; mn[1] = 0;
    repeat (2) step();
    in_rst_n = 1'b1;
    req(1, 3'b010, 32'h7FFF_FFFF, 0);
    req(0, 3'b000, 32'h5, 32'h5);
    drain(40);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters: requester 0 is the core datapath and requester 1 is the auxiliary address/branch unit. It arbitrates round-robin and latches the granted operands. It then drives the ALU for one execute cycle and returns a registered result with flags over a valid/ready response channel. It also keeps per-requester zero/negative flags, so that a pass operation from one requester never reports flags produced by the other.

## Interface
- WIDTH, 32, operand/result width.
- in_clk  input  1  clock, rising edge.
- in_rst_n  input  1  reset, asynchronous, active-low.
- in_req_valid  input  2  per-requester request valid.
- in_req_a0 / in_req_a1  input  WIDTH  operand A, requester 0 / 1.
- in_req_b0 / in_req_b1  input  WIDTH  operand B, requester 0 / 1.
- in_req_op0 / in_req_op1  input  3  ALU opcode, requester 0 / 1.
- out_req_ready  output  2  per-requester accept; one-hot or zero.
- out_alu_a, out_alu_b  output  WIDTH  ALU operands.
- out_alu_op  output  3  ALU opcode.
- in_alu_result  input  WIDTH  ALU result.
- in_alu_zero, in_alu_neg  input  1  ALU flags.
- out_rsp_valid  output  1  response valid.
- out_rsp_id  output  1  requester the response belongs to.
- out_rsp_result  output  WIDTH  registered result.
- out_rsp_zero, out_rsp_neg  output  1  flags for that requester.
- out_rsp_err  output  1  illegal opcode.
- in_rsp_ready  input  1  response consumer ready.

## Operation
- Opcodes: 100 ADD (b+a), 010 INC (a+1), 001 NEG (-a), 000 SUB (b-a), 111 PASS (a).
  - 011, 101 and 110 are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the single valid requester. When both are valid, the round-robin pointer decides.
  - out_req_ready[grant] = 1 combinationally.
  - On valid&ready, latch a, b, op and id, then move the pointer to the other requester.
  - Legal op -> EXEC. Illegal op -> RESP with err=1, result=0 and that requester's flags unchanged.
- EXEC:
  - Drive out_alu_* from the latched registers.
  - At the clock edge, capture in_alu_result into the response register.
  - Non-PASS: capture in_alu_zero/neg into the response and into flag register [id].
  - PASS: response flags = flag register [id]; ALU flags are ignored.
  - Next state is RESP.
- RESP:
  - out_rsp_valid = 1; all response fields stay stable.
  - On in_rsp_ready, go to IDLE.
  - out_req_ready = 0 throughout.
- Outside EXEC, the ALU ports are driven with op=111, a=0, b=0 (PASS leaves ALU flags untouched).
- Requesters hold valid and payload stable until accepted. Dropping valid before acceptance is allowed (no grant results).

## Timing
- Reset values:
  - State IDLE; pointer selects requester 0.
  - out_rsp_valid=0, out_rsp_id=0, out_rsp_result=0, out_rsp_zero=0, out_rsp_neg=0, out_rsp_err=0.
  - Both flag registers 0; out_alu_op=111, out_alu_a=0, out_alu_b=0.
  - out_req_ready=0 when no valid is present.
- Latency:
  - Accept at edge N, EXEC during cycle N+1, out_rsp_valid from cycle N+2.
  - Illegal op: out_rsp_valid from cycle N+1.
- Throughput: one operation per 3 cycles at best. If in_rsp_ready is low, the FSM stays in RESP indefinitely.
- After the RESP handshake, IDLE lasts at least one cycle before the next accept.
- Simultaneous valid: the requester at the pointer wins, and the loser is granted next. Fairness: neither requester waits more than one other operation.
- Reset asserted mid-operation: immediate return to reset values. The in-flight request and response are dropped and the requester reissues.
- Arithmetic is modulo 2^WIDTH, with no carry or overflow output.
  - NEG of 0 gives 0 with zero=1.
  - SUB 0-1 gives all-ones with neg=1.

## Structure
- Shared package alu_pkg:
  - Opcode constants ALU_ADD, ALU_INC, ALU_NEG, ALU_SUB, ALU_PASS.
  - Function alu_op_legal().
  - State enum (IDLE/EXEC/RESP).
  - The ALU and other ALU clients import the same package.
- Sub-module rr_arb2: two-input round-robin picker with registered pointer, inputs valid[1:0] and advance, output one-hot grant.
- The ALU itself stays external to this block.

## Test plan
- Single request: requester 0 sends ADD a=5, b=7 -> rsp id=0, result=12, zero=0, neg=0, valid at accept+2.
- Contention: both valid after reset, requester 0 INC a=1 and requester 1 SUB a=3, b=3 -> requester 0 served first (result 2), then requester 1 (result 0, zero=1). With both still asserted, grants alternate strictly.
- Flag isolation:
  - Requester 1 SUB a=1, b=0 gives result 0xFFFFFFFF, neg=1.
  - Then requester 0 PASS a=9 gives result 9, zero=0, neg=0 (requester 0's flags, not requester 1's).
- Illegal op: requester 1 op=101 -> err=1, result=0, flags unchanged; the ALU never sees op 101.
- Backpressure: hold in_rsp_ready=0 for 10 cycles -> response stays stable and valid, out_req_ready stays 0, and no second request is accepted.
- Mid-operation reset: assert in_rst_n=0 during EXEC -> all outputs return to reset values asynchronously. After release, requester 0 is granted first.
